vga_frame_pipeline: RTL and testbench

VGA_FRAME_PIPELINE -- requirements
Module: vga_frame_pipeline

---
 rtl/vga_frame_pipeline.sv | 219 +++++++++++++++++++++
 tb/tb_vga_frame_pipeline.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_pipeline.sv
// VGA timing generator driving a double-buffered, upscaled RGB332 frame buffer.
// A writer fills the back buffer; buffers swap at the start of vertical blanking.
module vga_frame_pipeline #(
  parameter int  H_ACTIVE   = 640,
  parameter int  H_FP       = 16,
  parameter int  H_SYNC     = 96,
  parameter int  H_BP       = 48,
  parameter int  V_ACTIVE   = 480,
  parameter int  V_FP       = 10,
  parameter int  V_SYNC     = 2,
  parameter int  V_BP       = 33,
  parameter int  CLK_DIV    = 4,
  parameter int  FB_W       = 40,
  parameter int  FB_H       = 30,
  parameter int  SCALE_LOG2 = 4,
  parameter bit  SYNC_POL   = 1'b0,
  localparam int FB_SIZE    = FB_W * FB_H,
  localparam int AW         = $clog2(FB_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          wr_last,
  output logic          hsync,
  output logic          vsync,
  output logic [3:0]    red,
  output logic [3:0]    green,
  output logic [3:0]    blue,
  output logic          frame_start,
  output logic          swap_done
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int CW      = $clog2(CLK_DIV);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_FILL    = 2'd1,
    ST_PENDING = 2'd2
  } wr_state_t;

  function automatic logic [11:0] expand_rgb332(input logic [7:0] p);
    return {p[7:5], p[7], p[4:2], p[4], p[1:0], p[1:0]};
  endfunction

  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic [HW-1:0] hc_q, hc_d;
  logic [VW-1:0] vc_q, vc_d;
  wr_state_t     state_q, state_d;
  logic          front_q;
  logic          wr_ready_q;
  logic          frame_start_q;
  logic          swap_done_q;

  logic          act1_q, hs1_q, vs1_q, sel1_q;
  logic          hsync_q, vsync_q;
  logic [3:0]    red_q, green_q, blue_q;

  logic [7:0]    buf0_q [FB_SIZE];
  logic [7:0]    buf1_q [FB_SIZE];
  logic [7:0]    rd0_q, rd1_q;

  logic          tick_s, h_wrap_s, v_wrap_s;
  logic          active_s, hs_act_s, vs_act_s;
  logic          swap_s, frame_wrap_s;
  logic          wr_fire_s, wr_in_range_s, we0_s, we1_s;
  logic [AW-1:0] rd_addr_s;
  logic [7:0]    px_s;
  logic [11:0]   rgb_s;

  assign tick_s   = (tick_cnt_q == CW'(CLK_DIV - 1));
  assign h_wrap_s = (hc_q == HW'(H_TOTAL - 1));
  assign v_wrap_s = (vc_q == VW'(V_TOTAL - 1));

  assign active_s = (hc_q < HW'(H_ACTIVE)) && (vc_q < VW'(V_ACTIVE));
  assign hs_act_s = (hc_q >= HW'(H_ACTIVE + H_FP)) && (hc_q < HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_act_s = (vc_q >= VW'(V_ACTIVE + V_FP)) && (vc_q < VW'(V_ACTIVE + V_FP + V_SYNC));

  // Swap only on the tick that moves the raster onto the first blanking line.
  assign swap_s       = tick_s && h_wrap_s && (vc_q == VW'(V_ACTIVE - 1)) && (state_q == ST_PENDING);
  assign frame_wrap_s = tick_s && h_wrap_s && v_wrap_s;

  assign wr_fire_s     = wr_valid && wr_ready_q;
  assign wr_in_range_s = ({1'b0, wr_addr} < (AW + 1)'(FB_SIZE));
  assign we0_s         = wr_fire_s && wr_in_range_s && front_q;
  assign we1_s         = wr_fire_s && wr_in_range_s && !front_q;

  assign px_s  = sel1_q ? rd1_q : rd0_q;
  assign rgb_s = expand_rgb332(px_s);

  // Next-state for the pixel tick divider and raster counters.
  always_comb begin
    tick_cnt_d = tick_s ? '0 : tick_cnt_q + CW'(1);
    hc_d       = hc_q;
    vc_d       = vc_q;
    if (tick_s) begin
      if (h_wrap_s) begin
        hc_d = '0;
        vc_d = v_wrap_s ? '0 : vc_q + VW'(1);
      end else begin
        hc_d = hc_q + HW'(1);
      end
    end else begin
      hc_d = hc_q;
    end
  end

  // Raster counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
      hc_q       <= '0;
      vc_q       <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      hc_q       <= hc_d;
      vc_q       <= vc_d;
    end
  end

  // Buffer read address; scaled down raster position, parked at 0 in blanking.
  always_comb begin
    rd_addr_s = '0;
    if (active_s) begin
      rd_addr_s = AW'(((int'(vc_q) >> SCALE_LOG2) * FB_W) + (int'(hc_q) >> SCALE_LOG2));
    end else begin
      rd_addr_s = '0;
    end
  end

  // Buffer 0 storage: written while it is the back buffer, read every tick.
  always_ff @(posedge clk) begin
    if (we0_s) buf0_q[wr_addr] <= wr_data;
    if (tick_s) rd0_q <= buf0_q[rd_addr_s];
  end

  // Buffer 1 storage.
  always_ff @(posedge clk) begin
    if (we1_s) buf1_q[wr_addr] <= wr_data;
    if (tick_s) rd1_q <= buf1_q[rd_addr_s];
  end

  // Writer state machine next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: state_d = ST_FILL;
      ST_FILL: begin
        if (wr_fire_s && wr_last) state_d = ST_PENDING;
        else                      state_d = ST_FILL;
      end
      ST_PENDING: begin
        if (swap_s) state_d = ST_FILL;
        else        state_d = ST_PENDING;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Writer state, front-buffer index and event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_INIT;
      front_q       <= 1'b0;
      wr_ready_q    <= 1'b0;
      frame_start_q <= 1'b0;
      swap_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      front_q       <= front_q ^ swap_s;
      wr_ready_q    <= (state_d == ST_FILL);
      frame_start_q <= frame_wrap_s;
      swap_done_q   <= swap_s;
    end
  end

  // Two-tick video pipeline: stage 1 tracks the memory read, stage 2 drives pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      act1_q  <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      sel1_q  <= 1'b0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      red_q   <= 4'h0;
      green_q <= 4'h0;
      blue_q  <= 4'h0;
    end else if (tick_s) begin
      act1_q  <= active_s;
      hs1_q   <= hs_act_s;
      vs1_q   <= vs_act_s;
      sel1_q  <= front_q;
      hsync_q <= hs1_q ? SYNC_POL : ~SYNC_POL;
      vsync_q <= vs1_q ? SYNC_POL : ~SYNC_POL;
      red_q   <= act1_q ? rgb_s[11:8] : 4'h0;
      green_q <= act1_q ? rgb_s[7:4]  : 4'h0;
      blue_q  <= act1_q ? rgb_s[3:0]  : 4'h0;
    end else begin
      act1_q  <= act1_q;
    end
  end

  assign wr_ready    = wr_ready_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign frame_start = frame_start_q;
  assign swap_done   = swap_done_q;

endmodule

// File: tb/tb_vga_frame_pipeline.sv
// Scoreboard bench for vga_frame_pipeline on a reduced 14x10 raster with a 4x3 buffer.
module tb_vga_frame_pipeline;

  localparam int HT = 14;
  localparam int VT = 10;
  localparam int FT = HT * VT;
  localparam int CD = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [3:0] wr_addr = 4'd0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_last = 1'b0;
  logic       hsync, vsync, frame_start, swap_done;
  logic [3:0] red, green, blue;

  vga_frame_pipeline #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .CLK_DIV(CD), .FB_W(4), .FB_H(3), .SCALE_LOG2(1), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_last(wr_last),
    .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .frame_start(frame_start), .swap_done(swap_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // mask: [0] video pins, [1] frame_start, [2] swap_done, [3] wr_ready
  typedef struct {
    int         cyc;
    logic [3:0] mask;
    logic [3:0] r, g, b;
    logic       hs, vs, fs, sd, rdy;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   base = 0;

  logic [7:0] pat [12] = '{8'h00, 8'h1C, 8'h03, 8'h92, 8'h49, 8'hFF,
                           8'h24, 8'hB6, 8'h6D, 8'hE3, 8'h1F, 8'hDB};

  function automatic void exp_px(int f, int h, int v, logic [11:0] rgb, string nm);
    exp_t e;
    e.cyc  = base + CD * (f * FT + v * HT + h + 2);
    e.mask = 4'b0001;
    {e.r, e.g, e.b} = rgb;
    e.hs   = !(h >= 10 && h < 12);
    e.vs   = !(v == 7);
    e.fs   = 1'b0;
    e.sd   = 1'b0;
    e.rdy  = 1'b0;
    e.name = nm;
    sb.push_back(e);
  endfunction

  function automatic void exp_ctl(int c, logic [3:0] m, logic fs, logic sd, logic rdy, string nm);
    exp_t e;
    e.cyc  = c;
    e.mask = m;
    e.r = 4'h0; e.g = 4'h0; e.b = 4'h0;
    e.hs = 1'b1; e.vs = 1'b1;
    e.fs = fs; e.sd = sd; e.rdy = rdy;
    e.name = nm;
    sb.push_back(e);
  endfunction

  // Monitor: compare every expectation due on this clock, flag any that slipped past.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        bit ok;
        ok = 1'b1;
        if (sb[i].mask[0] && ({red, green, blue, hsync, vsync} !==
            {sb[i].r, sb[i].g, sb[i].b, sb[i].hs, sb[i].vs})) ok = 1'b0;
        if (sb[i].mask[1] && (frame_start !== sb[i].fs)) ok = 1'b0;
        if (sb[i].mask[2] && (swap_done !== sb[i].sd)) ok = 1'b0;
        if (sb[i].mask[3] && (wr_ready !== sb[i].rdy)) ok = 1'b0;
        checks++;
        if (!ok) begin
          failures++;
          $display("FAIL %s cyc=%0d got rgb=%h%h%h hs=%b vs=%b fs=%b sd=%b rdy=%b want rgb=%h%h%h hs=%b vs=%b fs=%b sd=%b rdy=%b (mask=%b)",
                   sb[i].name, cyc, red, green, blue, hsync, vsync, frame_start, swap_done, wr_ready,
                   sb[i].r, sb[i].g, sb[i].b, sb[i].hs, sb[i].vs, sb[i].fs, sb[i].sd, sb[i].rdy, sb[i].mask);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s missed sample at cyc=%0d (now %0d)", sb[i].name, sb[i].cyc, cyc);
        sb.delete(i);
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic last, input bit chk_rdy);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_last  = last;
    while (!got && n < 50) begin
      @(negedge clk);
      got = wr_ready;
      @(posedge clk);
      n++;
    end
    #1;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL wr_accept addr=%0d got wr_ready=0 for %0d clocks want 1", a, n);
    end
    if (chk_rdy) exp_ctl(cyc, 4'b1000, 1'b0, 1'b0, 1'b1, "oor_ready_held");
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    base = cyc + 2;
    exp_ctl(base - 1, 4'b1111, 1'b0, 1'b0, 1'b0, "rst_hold");
    exp_ctl(base,     4'b1111, 1'b0, 1'b0, 1'b0, "rst_first_clk");
    exp_ctl(base + 1, 4'b1000, 1'b0, 1'b0, 1'b1, "rst_ready");
    wait_cyc(base);
    rst = 1'b0;
  endtask

  initial begin
    int t;
    do_reset();
    exp_ctl(base + 2, 4'b0010, 1'b0, 1'b0, 1'b0, "fs_idle");

    // Buffer 1 all red, completed early in frame 0.
    wait_cyc(base + 2);
    for (int i = 0; i < 12; i++) wr(4'(i), 8'hE0, (i == 11), 1'b0);
    exp_ctl(cyc, 4'b1000, 1'b0, 1'b0, 1'b0, "pending_ready_low");
    exp_ctl(base + 166, 4'b0100, 1'b0, 1'b0, 1'b0, "swap1_early");
    exp_ctl(base + 168, 4'b0100, 1'b0, 1'b1, 1'b0, "swap1");
    exp_ctl(base + 280, 4'b0010, 1'b1, 1'b0, 1'b0, "frame1_start");
    exp_ctl(base + 282, 4'b0010, 1'b0, 1'b0, 1'b0, "frame1_start_end");
    exp_px(1, 0, 0, 12'hF00, "f1_red_00");
    exp_px(1, 7, 5, 12'hF00, "f1_red_75");
    exp_px(1, 8, 0, 12'h000, "f1_hblank");
    exp_px(1, 9, 0, 12'h000, "f1_hs_pre");
    exp_px(1, 10, 0, 12'h000, "f1_hs_first");
    exp_px(1, 11, 0, 12'h000, "f1_hs_last");
    exp_px(1, 12, 0, 12'h000, "f1_hs_post");
    exp_px(1, 0, 6, 12'h000, "f1_vblank");
    exp_px(1, 0, 7, 12'h000, "f1_vs");
    exp_px(1, 13, 7, 12'h000, "f1_vs_lineend");
    exp_px(1, 0, 8, 12'h000, "f1_vs_post");

    // Buffer 0 pattern plus two out-of-range writes that must vanish.
    wait_cyc(base + 170);
    for (int i = 0; i < 11; i++) wr(4'(i), pat[i], 1'b0, 1'b0);
    wr(4'd12, 8'h55, 1'b0, 1'b1);
    wr(4'd15, 8'hAA, 1'b0, 1'b1);
    wr(4'd11, pat[11], 1'b1, 1'b0);
    exp_ctl(base + 300, 4'b1000, 1'b0, 1'b0, 1'b0, "pending_b_ready");
    exp_ctl(base + 448, 4'b1100, 1'b0, 1'b1, 1'b1, "swap2_ready");
    exp_px(2, 0, 0, 12'h000, "f2_idx0");
    exp_px(2, 3, 1, 12'h0F0, "f2_idx1");
    exp_px(2, 4, 0, 12'h00F, "f2_idx2");
    exp_px(2, 7, 1, 12'h99A, "f2_idx3");
    exp_px(2, 1, 2, 12'h445, "f2_idx4");
    exp_px(2, 2, 3, 12'hFFF, "f2_idx5");
    exp_px(2, 5, 2, 12'h220, "f2_idx6");
    exp_px(2, 6, 3, 12'hBBA, "f2_idx7");
    exp_px(2, 0, 4, 12'h665, "f2_idx8");
    exp_px(2, 3, 5, 12'hF0F, "f2_idx9");
    exp_px(2, 4, 4, 12'h0FF, "f2_idx10");
    exp_px(2, 7, 5, 12'hDDF, "f2_idx11");

    // Single white buffer pixel over the red buffer.
    wait_cyc(base + 452);
    wr(4'd5, 8'hFF, 1'b1, 1'b0);
    exp_ctl(base + 728, 4'b0100, 1'b0, 1'b1, 1'b0, "swap3");

    // Frame completed on line 8: must wait for the next frame's swap point.
    wait_cyc(base + 784);
    wr(4'd0, 8'h03, 1'b1, 1'b0);
    exp_ctl(base + 840, 4'b1010, 1'b1, 1'b0, 1'b0, "late_pending_f3");
    exp_ctl(base + 1008, 4'b0100, 1'b0, 1'b1, 1'b0, "swap4_late");
    exp_ctl(base + 1288, 4'b0100, 1'b0, 1'b0, 1'b0, "no_swap_idle");
    exp_px(3, 1, 2, 12'hF00, "f3_before_white");
    exp_px(3, 2, 2, 12'hFFF, "f3_white_first");
    exp_px(3, 3, 3, 12'hFFF, "f3_white_last");
    exp_px(3, 4, 2, 12'hF00, "f3_after_white");
    exp_px(3, 2, 1, 12'hF00, "f3_above_white");
    exp_px(3, 2, 4, 12'hF00, "f3_below_white");
    exp_px(4, 0, 0, 12'h00F, "f4_idx0_new");
    exp_px(4, 1, 1, 12'h00F, "f4_idx0_corner");
    exp_px(4, 2, 0, 12'h0F0, "f4_idx1");
    exp_px(4, 7, 5, 12'hDDF, "f4_idx11");

    // Pending swap, then reset before it can happen.
    wait_cyc(base + 1290);
    wr(4'd0, 8'h1C, 1'b1, 1'b0);
    exp_px(5, 0, 0, 12'h00F, "f5_front_kept");
    exp_px(5, 5, 2, 12'h220, "f5_idx6");
    wait_cyc(base + 1484);
    do_reset();
    exp_px(0, 0, 0, 12'h00F, "rst_f0_idx0");
    exp_ctl(base + 168, 4'b0100, 1'b0, 1'b0, 1'b0, "rst_no_swap");
    exp_ctl(base + 280, 4'b0010, 1'b1, 1'b0, 1'b0, "rst_frame1_start");
    exp_px(1, 7, 5, 12'hDDF, "rst_f1_idx11");
    exp_px(1, 3, 1, 12'h0F0, "rst_f1_idx1");

    t = 0;
    while (sb.size() > 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    foreach (sb[i]) begin
      checks++;
      failures++;
      $display("FAIL %s never sampled (due cyc=%0d)", sb[i].name, sb[i].cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
